// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
//   alu_op_t    - 3-bit opcode carried on the op port
//   alu_state_t - control FSM state (idle / iterative divide)
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIVU = 3'd3,
    OP_REMU = 3'd4,
    OP_AND  = 3'd5,
    OP_OR   = 3'd6,
    OP_XOR  = 3'd7
  } alu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (aborts a divide)
//   start               load dividend/divisor and begin (divisor must be nonzero)
//   dividend, divisor   operands, sampled only when start is high
//   busy                a divide is in progress
//   done                final step is being taken this cycle; quotient/remainder valid
//   quotient, remainder results of the current step (meaningful when done)
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(WIDTH);

  // rem_q holds the partial remainder already shifted left with the next dividend bit
  // appended, so each cycle only needs one trial subtraction.
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;  // remaining dividend bits shift out the top, quotient bits in
  logic [WIDTH-1:0] dvs_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  always_comb begin
    trial    = rem_q - {1'b0, dvs_q};
    // Negative trial: restore (keep the shifted remainder), quotient bit 0.
    rem_step = trial[WIDTH] ? rem_q[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == '0);
  assign quotient  = quo_step;
  assign remainder = rem_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= {{WIDTH{1'b0}}, dividend[WIDTH-1]};
      quo_q  <= {dividend[WIDTH-2:0], 1'b0};
      dvs_q  <= divisor;
      cnt_q  <= CntW'(WIDTH - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= {rem_step, quo_q[WIDTH-1]};
      quo_q <= quo_step;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: ADD/SUB/MUL/AND/OR/XOR in one cycle, DIVU/REMU on an
// iterative divider taking WIDTH cycles. Result and flags are registered.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake; op, a, b sampled on the accept edge
//   op, a, b              opcode (alu_op_t) and unsigned operands
//   out_valid/out_ready   result handshake; result and flags hold while stalled
//   result                operation result
//   flag_zero             result == 0
//   flag_carry            ADD carry-out / SUB borrow
//   flag_ovf              ADD/SUB signed overflow, MUL high half nonzero
//   flag_dz               DIVU/REMU with b == 0
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_dz
);

  alu_state_t       state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;
  logic             ovf_q;
  logic             dz_q;
  logic             div_rem_q;  // in-flight divide returns the remainder

  alu_op_t          op_dec;
  logic             accept;
  logic             b_zero;
  logic             is_div;
  logic             div_start;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_carry;
  logic                 sc_ovf;
  logic                 sc_dz;

  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_res;

  assign op_dec    = alu_op_t'(op);
  assign in_ready  = (state_q == S_IDLE) && !div_busy && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign b_zero    = (b == '0);
  assign is_div    = (op_dec == OP_DIVU) || (op_dec == OP_REMU);
  assign div_start = accept && is_div && !b_zero;
  assign div_res   = div_rem_q ? div_rem : div_quo;

  // Single-cycle datapath, also covers divide-by-zero.
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_dz    = 1'b0;
    unique case (op_dec)
      OP_ADD: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = diff[WIDTH];
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: begin
        sc_res = prod[WIDTH-1:0];
        sc_ovf = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIVU: begin
        sc_res = '1;
        sc_dz  = 1'b1;
      end
      OP_REMU: begin
        sc_res = a;
        sc_dz  = 1'b1;
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      default: sc_res = '0;
    endcase
  end

  div_unit #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (a),
    .divisor  (b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      div_rem_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_start) begin
            // Accept implies the previous result is gone or draining now.
            state_q     <= S_DIV;
            div_rem_q   <= (op_dec == OP_REMU);
            out_valid_q <= 1'b0;
          end else if (accept) begin
            result_q    <= sc_res;
            zero_q      <= (sc_res == '0);
            carry_q     <= sc_carry;
            ovf_q       <= sc_ovf;
            dz_q        <= sc_dz;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        S_DIV: begin
          if (div_done) begin
            result_q    <= div_res;
            zero_q      <= (div_res == '0);
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;
  assign flag_dz    = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 with hand-computed expected values.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_ovf;
  logic             flag_dz;

  int checks   = 0;
  int failures = 0;

  seq_alu #(
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_zero (flag_zero),
    .flag_carry(flag_carry),
    .flag_ovf  (flag_ovf),
    .flag_dz   (flag_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, let it be accepted, then scramble operands.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] va,
                       input logic [WIDTH-1:0] vb);
    op       = o;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    op       = 3'($urandom_range(0, 7));
  endtask

  task automatic check_out(input string tag, input logic [WIDTH-1:0] res, input logic z,
                           input logic c, input logic v, input logic d);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".result"}, 64'(result), 64'(res));
    check({tag, ".zero"}, 64'(flag_zero), 64'(z));
    check({tag, ".carry"}, 64'(flag_carry), 64'(c));
    check({tag, ".ovf"}, 64'(flag_ovf), 64'(v));
    check({tag, ".dz"}, 64'(flag_dz), 64'(d));
  endtask

  // Multi-cycle op: bounded wait for out_valid, checking latency and in_ready low.
  task automatic run_div(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] va,
                         input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] res);
    int cycles;
    int ready_seen;
    cycles     = 0;
    ready_seen = 0;
    do_op(tag, o, va, vb);
    while (!out_valid && cycles < 40) begin
      if (in_ready) ready_seen++;
      step();
      cycles++;
    end
    check({tag, ".latency"}, 64'(cycles), 64'd32);
    check({tag, ".ready_low"}, 64'(ready_seen), 64'd0);
    check_out(tag, res, (res == '0), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int highs;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 3'd0;
    a         = '0;
    b         = '0;

    #23;
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.flags", 64'({flag_zero, flag_carry, flag_ovf, flag_dz}), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    #4 rst_n = 1'b1;
    step();

    // Single-cycle ops.
    do_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1);
    check_out("add_wrap", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1);
    check_out("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1);
    check_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op("sub_borrow", OP_SUB, 32'd3, 32'd5);
    check_out("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("mul_hi", OP_MUL, 32'h0001_0000, 32'h0001_0000);
    check_out("mul_hi", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op("mul_lo", OP_MUL, 32'h1234, 32'h10);
    check_out("mul_lo", 32'h0001_2340, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("add_c", OP_ADD, 32'hFFFF_FFFF, 32'd2);
    check_out("add_c", 32'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("and", OP_AND, 32'hFFFF_F0F0, 32'hFF00_FF00);
    check_out("and", 32'hFF00_F000, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("or", OP_OR, 32'h0000_00F0, 32'h8000_000F);
    check_out("or", 32'h8000_00FF, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("xor", OP_XOR, 32'hAAAA_5555, 32'hAAAA_5555);
    check_out("xor", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Divider.
    run_div("divu", OP_DIVU, 32'd100, 32'd7, 32'd14);
    run_div("remu", OP_REMU, 32'd100, 32'd7, 32'd2);
    run_div("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
    run_div("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF);
    run_div("divu_small", OP_DIVU, 32'd7, 32'd9, 32'd0);
    run_div("remu_small", OP_REMU, 32'd7, 32'd9, 32'd7);
    do_op("divu_dz", OP_DIVU, 32'd5, 32'd0);
    check_out("divu_dz", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("remu_dz", OP_REMU, 32'd5, 32'd0);
    check_out("remu_dz", 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: result must hold and the queued request must wait.
    step();
    check("drain.valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    do_op("bp_add", OP_ADD, 32'd2, 32'd3);
    check_out("bp_add", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    op       = OP_XOR;
    a        = 32'hF0;
    b        = 32'hFF;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp.hold_result", 64'(result), 64'd5);
      check("bp.hold_valid", 64'(out_valid), 64'd1);
      check("bp.in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check_out("bp_xor", 32'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("bp.drained", 64'(out_valid), 64'd0);

    // Reset in the middle of a divide.
    do_op("rst_div", OP_DIVU, 32'd100, 32'd7);
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    check("rstdiv.valid", 64'(out_valid), 64'd0);
    check("rstdiv.result", 64'(result), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    check("rstdiv.in_ready", 64'(in_ready), 64'd1);
    do_op("post_rst_add", OP_ADD, 32'd1, 32'd1);
    check_out("post_rst_add", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) highs++;
    end
    check("rstdiv.no_stale_result", 64'(highs), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
